// File: rtl/mac_pm_pkg.sv
// Shared power-mode definitions for the MAC power-mode sequencer and MAC_UPF benches.
// Holds the mode and FSM encodings, the legality check and the hop-routing rules.
package mac_pm_pkg;

    localparam int unsigned PM_MODE_W = 3;

    typedef enum logic [PM_MODE_W-1:0] {
        PM_OFF = 3'b000,
        PM_RPM = 3'b001,
        PM_ESM = 3'b010,
        PM_LPM = 3'b011,
        PM_FPM = 3'b110
    } pm_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } pm_state_t;

    function automatic logic is_legal_mode(input logic [PM_MODE_W-1:0] code);
        logic legal;
        case (code)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b110: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // One step from cur toward tgt; FPM is only entered or left through ESM.
    function automatic pm_mode_t next_hop(input pm_mode_t cur, input pm_mode_t tgt);
        pm_mode_t hop;
        hop = tgt;
        if (tgt == PM_OFF) begin
            hop = PM_OFF;
        end else if (cur == PM_OFF) begin
            hop = PM_RPM;
        end else if ((tgt == PM_FPM) && (cur != PM_ESM)) begin
            hop = PM_ESM;
        end else if (cur == PM_FPM) begin
            hop = PM_ESM;
        end
        return hop;
    endfunction

endpackage

// File: rtl/pm_settle_timer.sv
// Loadable down-counter timing the drain and supply-settle intervals.
// done is asserted during the last cycle of a loaded interval.
module pm_settle_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mac_pm_sequencer.sv
// Power-mode sequencer in front of MAC_UPF: accepts mode requests, gates the operand
// feed during a switch, and walks state_select through legal hops with settle time.
module mac_pm_sequencer
    import mac_pm_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES  = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + DRAIN_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    output logic [2:0] state_select,
    output logic       mac_enable,
    output logic       busy,
    output logic       mode_err
);

    pm_state_t        r_state;
    pm_state_t        w_state_nxt;
    pm_mode_t         r_sel;
    pm_mode_t         w_sel_nxt;
    pm_mode_t         r_target;
    pm_mode_t         w_target_nxt;
    logic             r_req_ready;
    logic             r_mac_enable;
    logic             r_busy;
    logic             r_mode_err;
    logic             w_mode_err_nxt;
    logic             w_accept;
    logic             w_tmr_start;
    logic             w_tmr_done;
    logic [CNT_W-1:0] w_tmr_load;

    assign w_accept = req_valid && r_req_ready;

    pm_settle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_tmr_start),
        .i_load   (w_tmr_load),
        .o_done_c (w_tmr_done)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_target_nxt   = r_target;
        w_mode_err_nxt = 1'b0;
        w_tmr_start    = 1'b0;
        w_tmr_load     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!is_legal_mode(req_mode)) begin
                        w_mode_err_nxt = 1'b1;
                    end else if (req_mode != r_sel) begin
                        w_target_nxt = pm_mode_t'(req_mode);
                        if (DRAIN_CYCLES == 0) begin
                            w_state_nxt = ST_SWITCH;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                            w_tmr_start = 1'b1;
                            w_tmr_load  = CNT_W'(DRAIN_CYCLES);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt   = next_hop(r_sel, r_target);
                w_tmr_start = 1'b1;
                w_tmr_load  = CNT_W'(SETTLE_CYCLES);
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Intermediate hops re-enter SWITCH directly; the feed is already drained.
                if (w_tmr_done) begin
                    w_state_nxt = (r_sel == r_target) ? ST_IDLE : ST_SWITCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= PM_OFF;
            r_target     <= PM_OFF;
            r_req_ready  <= 1'b1;
            r_mac_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_mode_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_target     <= w_target_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_mac_enable <= (w_state_nxt == ST_IDLE) && (w_sel_nxt != PM_OFF);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_mode_err   <= w_mode_err_nxt;
        end
    end

    assign req_ready    = r_req_ready;
    assign state_select = r_sel;
    assign mac_enable   = r_mac_enable;
    assign busy         = r_busy;
    assign mode_err     = r_mode_err;

endmodule

// File: tb/tb_mac_pm_sequencer.sv
// Bench for mac_pm_sequencer: two configurations checked every cycle against a
// timeline model built from the mode-routing graph, plus directed literal checks.
module tb_mac_pm_sequencer;

    localparam int D0 = 1;
    localparam int S0 = 4;
    localparam int D1 = 0;
    localparam int S1 = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       rdy;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rv    = '0;
    logic [2:0] rm [2];
    logic [2:0] sel [2];
    logic [1:0] en;
    logic [1:0] rdy;
    logic [1:0] bsy;
    logic [1:0] err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit         act [2];
    int         acc [2];
    int         tt [2];
    int         err_cyc [2];
    logic [2:0] from_m [2];
    logic [2:0] fin [2];
    logic [2:0] hops [2][3];

    int         m_o;
    int         m_n;
    bit         m_idle;
    logic [2:0] m_cur;
    logic [2:0] m_nxt;
    exp_t       ce;
    exp_t       pe;

    mac_pm_sequencer #(.DRAIN_CYCLES(D0), .SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_mode(rm[0]),
        .req_ready(rdy[0]), .state_select(sel[0]), .mac_enable(en[0]),
        .busy(bsy[0]), .mode_err(err[0])
    );

    mac_pm_sequencer #(.DRAIN_CYCLES(D1), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_mode(rm[1]),
        .req_ready(rdy[1]), .state_select(sel[1]), .mac_enable(en[1]),
        .busy(bsy[1]), .mode_err(err[1])
    );

    always #5 clk = ~clk;

    function automatic int dr(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int st(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic bit legal(input logic [2:0] c);
        return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd6);
    endfunction

    // Directly permitted transitions of the mode graph.
    function automatic bit edge_ok(input logic [2:0] a, input logic [2:0] b);
        bit mid_a;
        bit mid_b;
        mid_a = (a == 3'd1) || (a == 3'd2) || (a == 3'd3);
        mid_b = (b == 3'd1) || (b == 3'd2) || (b == 3'd3);
        return (b == 3'd0) || ((a == 3'd0) && (b == 3'd1)) || ((a == 3'd2) && (b == 3'd6))
            || ((a == 3'd6) && (b == 3'd2)) || (mid_a && mid_b);
    endfunction

    // Expected outputs in cycle c, from the offset since the accepting cycle.
    function automatic exp_t expect_at(input int i, input int c);
        exp_t e;
        int   o;
        int   k;
        int   h;
        int   p;
        e.err = (c == err_cyc[i]);
        o = c - acc[i];
        if (act[i] && (o >= 1) && (o <= tt[i])) begin
            e.en   = 1'b0;
            e.rdy  = 1'b0;
            e.busy = 1'b1;
            if (o <= dr(i)) begin
                e.sel = from_m[i];
            end else begin
                k = o - dr(i) - 1;
                h = k / (st(i) + 1);
                p = k % (st(i) + 1);
                if (p == 0) e.sel = (h == 0) ? from_m[i] : hops[i][h-1];
                else        e.sel = hops[i][h];
            end
        end else begin
            e.sel  = fin[i];
            e.en   = (fin[i] != 3'd0);
            e.rdy  = 1'b1;
            e.busy = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        end
    endtask

    // Model: accepts requests when idle and plans the hop path through the mode graph.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                act[i]     = 1'b0;
                fin[i]     = 3'd0;
                err_cyc[i] = -1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_o    = cyc - acc[i];
                m_idle = !(act[i] && (m_o >= 1) && (m_o <= tt[i]));
                if (m_idle && rv[i]) begin
                    if (!legal(rm[i])) begin
                        err_cyc[i] = cyc + 1;
                    end else if (rm[i] != fin[i]) begin
                        from_m[i] = fin[i];
                        m_cur     = fin[i];
                        m_n       = 0;
                        for (int k = 0; k < 3; k++) begin
                            if (m_cur != rm[i]) begin
                                if (edge_ok(m_cur, rm[i])) m_nxt = rm[i];
                                else if (m_cur == 3'd0)    m_nxt = 3'd1;
                                else                       m_nxt = 3'd2;
                                hops[i][k] = m_nxt;
                                m_cur      = m_nxt;
                                m_n++;
                            end
                        end
                        tt[i]  = dr(i) + m_n * (st(i) + 1);
                        acc[i] = cyc;
                        act[i] = 1'b1;
                        fin[i] = rm[i];
                    end
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ce = expect_at(i, cyc);
            chk($sformatf("u%0d_c%0d_sel", i, cyc),  32'(sel[i]), 32'(ce.sel));
            chk($sformatf("u%0d_c%0d_en", i, cyc),   32'(en[i]),  32'(ce.en));
            chk($sformatf("u%0d_c%0d_rdy", i, cyc),  32'(rdy[i]), 32'(ce.rdy));
            chk($sformatf("u%0d_c%0d_busy", i, cyc), 32'(bsy[i]), 32'(ce.busy));
            chk($sformatf("u%0d_c%0d_err", i, cyc),  32'(err[i]), 32'(ce.err));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input int i, input logic [2:0] m);
        rv[i] = 1'b1;
        rm[i] = m;
        tick(1);
        rv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (!(rdy[i] && !bsy[i]) && (n < 60)) begin
            tick(1);
            n++;
        end
        chk($sformatf("u%0d_idle_wait", i), 32'(rdy[i] && !bsy[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i]     = 1'b0;
            fin[i]     = 3'd0;
            err_cyc[i] = -1;
            rm[i]      = 3'd0;
        end
        #3 reset = 1'b0;
        tick(2);
        chk("rst_sel", 32'(sel[0]), 32'd0);
        chk("rst_en", 32'(en[0]), 32'd0);
        chk("rst_rdy", 32'(rdy[0]), 32'd1);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        reset = 1'b1;
        tick(1);

        // OFF -> RPM, single hop
        req(0, 3'b001);
        chk("rpm_c1_busy", 32'(bsy[0]), 32'd1);
        chk("rpm_c1_en", 32'(en[0]), 32'd0);
        chk("rpm_c1_rdy", 32'(rdy[0]), 32'd0);
        tick(1);
        chk("rpm_c2_sel", 32'(sel[0]), 32'd0);
        tick(1);
        chk("rpm_c3_sel", 32'(sel[0]), 32'd1);
        tick(3);
        chk("rpm_c6_rdy", 32'(rdy[0]), 32'd0);
        tick(1);
        chk("rpm_c7_rdy", 32'(rdy[0]), 32'd1);
        chk("rpm_c7_en", 32'(en[0]), 32'd1);

        // RPM -> FPM via ESM
        req(0, 3'b110);
        tick(2);
        chk("fpm_c3_sel", 32'(sel[0]), 32'd2);
        tick(4);
        chk("fpm_c7_sel", 32'(sel[0]), 32'd2);
        tick(1);
        chk("fpm_c8_sel", 32'(sel[0]), 32'd6);
        pe = expect_at(0, cyc);
        chk("model_c8_sel", 32'(pe.sel), 32'd6);
        tick(3);
        chk("fpm_c11_rdy", 32'(rdy[0]), 32'd0);
        tick(1);
        chk("fpm_c12_rdy", 32'(rdy[0]), 32'd1);
        chk("fpm_c12_en", 32'(en[0]), 32'd1);

        // FPM -> OFF direct
        req(0, 3'b000);
        tick(2);
        chk("off_c3_sel", 32'(sel[0]), 32'd0);
        wait_idle(0);
        chk("off_idle_en", 32'(en[0]), 32'd0);

        // OFF -> FPM, three hops
        req(0, 3'b110);
        tick(2);
        chk("off_fpm_c3_sel", 32'(sel[0]), 32'd1);
        tick(5);
        chk("off_fpm_c8_sel", 32'(sel[0]), 32'd2);
        tick(5);
        chk("off_fpm_c13_sel", 32'(sel[0]), 32'd6);
        tick(3);
        chk("off_fpm_c16_rdy", 32'(rdy[0]), 32'd0);
        pe = expect_at(0, cyc);
        chk("model_c16_busy", 32'(pe.busy), 32'd1);
        tick(1);
        chk("off_fpm_c17_rdy", 32'(rdy[0]), 32'd1);

        // FPM -> RPM, then RPM again as a no-op
        req(0, 3'b001);
        wait_idle(0);
        chk("rpm2_sel", 32'(sel[0]), 32'd1);
        req(0, 3'b001);
        chk("noop_c1_rdy", 32'(rdy[0]), 32'd1);
        chk("noop_c1_busy", 32'(bsy[0]), 32'd0);
        chk("noop_c1_en", 32'(en[0]), 32'd1);
        tick(2);
        chk("noop_c3_sel", 32'(sel[0]), 32'd1);
        chk("noop_c3_en", 32'(en[0]), 32'd1);

        // LPM, then an illegal code
        req(0, 3'b011);
        wait_idle(0);
        chk("lpm_sel", 32'(sel[0]), 32'd3);
        req(0, 3'b101);
        chk("ill_c1_err", 32'(err[0]), 32'd1);
        chk("ill_c1_sel", 32'(sel[0]), 32'd3);
        chk("ill_c1_en", 32'(en[0]), 32'd1);
        chk("ill_c1_rdy", 32'(rdy[0]), 32'd1);
        tick(1);
        chk("ill_c2_err", 32'(err[0]), 32'd0);

        // Reset asserted during SETTLE
        req(0, 3'b010);
        tick(3);
        chk("rs_c4_sel", 32'(sel[0]), 32'd2);
        chk("rs_c4_busy", 32'(bsy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rs_now_sel", 32'(sel[0]), 32'd0);
        chk("rs_now_en", 32'(en[0]), 32'd0);
        chk("rs_now_rdy", 32'(rdy[0]), 32'd1);
        chk("rs_now_busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        req(0, 3'b011);
        tick(2);
        chk("rs_lpm_c3_sel", 32'(sel[0]), 32'd1);
        wait_idle(0);
        chk("rs_lpm_sel", 32'(sel[0]), 32'd3);
        chk("rs_lpm_en", 32'(en[0]), 32'd1);

        // No-drain instance: held request while busy
        rv[1] = 1'b1;
        rm[1] = 3'b001;
        tick(1);
        chk("nd_c1_busy", 32'(bsy[1]), 32'd1);
        chk("nd_c1_sel", 32'(sel[1]), 32'd0);
        rm[1] = 3'b011;
        tick(1);
        chk("nd_c2_sel", 32'(sel[1]), 32'd1);
        tick(2);
        chk("nd_c4_rdy", 32'(rdy[1]), 32'd1);
        chk("nd_c4_busy", 32'(bsy[1]), 32'd0);
        chk("nd_c4_en", 32'(en[1]), 32'd1);
        tick(1);
        chk("nd_c5_busy", 32'(bsy[1]), 32'd1);
        chk("nd_c5_rdy", 32'(rdy[1]), 32'd0);
        rv[1] = 1'b0;
        tick(1);
        chk("nd_c6_sel", 32'(sel[1]), 32'd3);
        wait_idle(1);
        chk("nd_final_sel", 32'(sel[1]), 32'd3);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pm_sequencer.md
Name: mac_pm_sequencer

Overview:
- Power-mode sequencer sitting directly upstream of MAC_UPF.
- Accepts power-mode requests over a valid/ready handshake and drives the MAC's 3-bit state_select.
- Gates the operand feed (mac_enable) while a mode switch is in progress.
- Inserts drain and supply-settle intervals. Routes transitions that are not allowed directly through a legal intermediate mode.

Parameters:
- DRAIN_CYCLES, default 1: cycles mac_enable is held low before state_select changes. 0 skips the drain.
- SETTLE_CYCLES, default 4: cycles held after each state_select change for supplies to settle. Must be >= 1.
- CNT_W, default $clog2(SETTLE_CYCLES+DRAIN_CYCLES+1): internal counter width, derived. Do not override.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  mode request present
- req_mode  input  3  requested mode code
- req_ready  output  1  sequencer can accept a request (high only in IDLE)
- state_select  output  3  registered mode code to MAC_UPF
- mac_enable  output  1  permits the upstream stimulus/operand feed into the MAC
- busy  output  1  high in any state other than IDLE
- mode_err  output  1  one-cycle pulse when an illegal code is accepted

Behaviour:
- Mode codes:
  - OFF = 000
  - RPM = 001
  - ESM = 010
  - LPM = 011
  - FPM = 110
  - All other codes are illegal.
- Reset (reset=0, asynchronous): state_select=000 (OFF), mac_enable=0, req_ready=1, busy=0, mode_err=0, FSM=IDLE, counters=0.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_mode is captured into a target register at that edge. req_ready=0 from the next cycle until the return to IDLE.
- FSM states: IDLE, DRAIN, SWITCH, SETTLE.
- IDLE: mac_enable = (state_select != OFF). On accept:
  - Illegal code: mode_err=1 for the next cycle only; stay in IDLE; state_select unchanged.
  - Target equal to current mode: no-op; stay in IDLE; mac_enable does not drop.
  - Otherwise: go to DRAIN, or directly to SWITCH if DRAIN_CYCLES=0.
- DRAIN: mac_enable=0 for DRAIN_CYCLES cycles, then SWITCH.
- SWITCH (1 cycle): compute next hop; state_select takes the hop value at the end of this cycle; go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles. If the hop differs from the target, go back to SWITCH with no second drain. Otherwise go to IDLE.
- mac_enable=0 throughout DRAIN, SWITCH and SETTLE.
- Hop rules (next hop from current mode toward the target):
  - Target OFF: direct from any mode.
  - From OFF: always RPM first.
  - FPM reachable only from ESM: RPM or LPM -> FPM goes via ESM.
  - Leaving FPM for RPM or LPM goes via ESM.
  - All other pairs among RPM, LPM and ESM are direct.
- Maximum hop count is 3 (OFF -> RPM -> ESM -> FPM).
- Latency, single hop, with defaults:
  - Accept edge at cycle 0.
  - DRAIN at cycle 1, SWITCH at cycle 2.
  - New state_select visible from cycle 3; SETTLE cycles 3-6.
  - IDLE at cycle 7 with req_ready=1 and mac_enable=1.
- Each additional hop adds 1 + SETTLE_CYCLES cycles.
- Requests presented while busy are ignored and must be held by the requester; no queuing.
- Reset asserted mid-sequence: immediate return to the reset values above; any partial hop is abandoned.
- req_mode changing after acceptance has no effect.

Decomposition:
- Shared package mac_pm_pkg:
  - pm_mode_t enum with the five codes above
  - legality function is_legal_mode()
  - next_hop() function implementing the hop rules
- The package is reused by MAC_UPF benches for mode-name printing.
- One sub-module, pm_settle_timer: loadable down-counter (load value, start, done pulse) shared by DRAIN and SETTLE.

Test Plan:
- Reset then req RPM (001): state_select=001 visible at cycle 3; req_ready back high and mac_enable=1 at cycle 7.
- From RPM, req FPM (110): state_select sequence 010 at cycle 3, then 110 at cycle 8; IDLE at cycle 12. Also check OFF -> FPM gives three hops (001, 010, 110).
- In RPM, req RPM again: no FSM exit; mac_enable stays 1; req_ready stays 1.
- Req illegal code 101 in LPM: mode_err high exactly one cycle; state_select stays 011; mac_enable unaffected.
- Req LPM, then assert reset=0 during SETTLE: within the same cycle, state_select=000, mac_enable=0 and req_ready=1; after release a new request is accepted normally.
- With DRAIN_CYCLES=0, req_valid held during busy: SWITCH immediately follows accept; the held second request is accepted only on the first IDLE cycle.
